// File: rtl/axi4stream_pkg.sv
// ---------------------------------------------------------------------------
// axi4stream_pkg
//
// Shared definitions for the AXI4-Stream buffer blocks of the video pipeline.
// The input-buffer deserializer uses this package, and so does the
// output-buffer serializer that feeds it. Sharing it keeps both sides in
// agreement on the counter sizing and on how wide the final beat is.
//
// Contents:
//   state_t        - FILL (collecting beats) / HOLD (buffer waiting downstream)
//   counterWidth   - beat counter width for a given beat count, minimum 1
//   lastBeatWidth  - number of meaningful bits carried by the final beat
// ---------------------------------------------------------------------------
package axi4stream_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // $clog2(1) is 0, which would give a zero-width counter for a
    // single-beat buffer, so the width never drops below one bit.
    function automatic int counterWidth(input int numPackets);
        return (numPackets > 1) ? $clog2(numPackets) : 1;
    endfunction

    // The buffer width need not be a multiple of the beat width. The final
    // beat therefore carries only the bits that remain.
    function automatic int lastBeatWidth(input int bufferWidth,
                                         input int axiWidth,
                                         input int numPackets);
        return bufferWidth - (numPackets - 1) * axiWidth;
    endfunction

endpackage

// File: rtl/axi4stream_input_buffer.sv
// ---------------------------------------------------------------------------
// axi4stream_input_buffer
//
// AXI4-Stream slave that deserializes NUM_PACKETS narrow beats into one wide
// buffer. Beats are written LSB-first, so beat k lands at
// [k*AXI_WIDTH +: AXI_WIDTH]. This matches the send order of the upstream
// serializer. When the buffer is complete it is held with
// output_buffer_valid asserted. During that time tready is low and upstream
// is stalled, until downstream takes the buffer with output_buffer_ready.
//
// Ports:
//   aclk, areset         - clock, asynchronous active-high reset
//   tdata/tvalid/tlast   - incoming stream beat
//   tready               - beat accepted (FILL state, not in reset)
//   output_buffer        - assembled buffer
//   output_buffer_valid  - buffer complete and stable (HOLD state)
//   output_buffer_ready  - downstream takes the buffer
//   err_early_tlast      - one-cycle pulse, tlast before the final beat
//   err_missing_tlast    - one-cycle pulse, final beat without tlast
//
// Optional feature: define AXIS_INPUT_BUFFER_TLAST_CHECK_EN to enable tlast
// framing checks. Without it, tlast is ignored, framing is purely by beat
// count, and both error outputs stay 0.
// ---------------------------------------------------------------------------
module axi4stream_input_buffer
    import axi4stream_pkg::*;
#(
    parameter int AXI_WIDTH    = 8,
    parameter int BUFFER_WIDTH = 80,
    parameter int NUM_PACKETS  = 10
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [AXI_WIDTH-1:0]    tdata,
    input  logic                    tvalid,
    input  logic                    tlast,
    output logic                    tready,
    output logic [BUFFER_WIDTH-1:0] output_buffer,
    output logic                    output_buffer_valid,
    input  logic                    output_buffer_ready,
    output logic                    err_early_tlast,
    output logic                    err_missing_tlast
);

    localparam int CNT_W   = counterWidth(NUM_PACKETS);
    localparam int LAST_W  = lastBeatWidth(BUFFER_WIDTH, AXI_WIDTH, NUM_PACKETS);
    localparam int LAST_LO = (NUM_PACKETS - 1) * AXI_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PACKETS - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [BUFFER_WIDTH-1:0] buffer_q, buffer_d;
    logic                    errEarly_q, errEarly_d;
    logic                    errMissing_q, errMissing_d;
    logic                    beatXfer;

`ifndef AXIS_INPUT_BUFFER_TLAST_CHECK_EN
    // Framing is by count alone, so tlast has no reader in this build.
    logic unusedTlast;
    assign unusedTlast = tlast;
`endif

    // tready is a pure decode of the state. It is forced low during reset so
    // that upstream never sees a handshake while the block is being cleared.
    assign tready              = (state_q == FILL) && !areset;
    assign beatXfer            = tvalid && tready;
    assign output_buffer       = buffer_q;
    assign output_buffer_valid = (state_q == HOLD);
    assign err_early_tlast     = errEarly_q;
    assign err_missing_tlast   = errMissing_q;

    // Next-state logic. The counter selects which slice of the buffer the
    // accepted beat overwrites. The final beat moves the block to HOLD. HOLD
    // returns to FILL when downstream takes the buffer, and that edge accepts
    // no beat because tready was low during it. Error flags default to 0, so
    // each error is a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        buffer_d     = buffer_q;
        errEarly_d   = 1'b0;
        errMissing_d = 1'b0;

        if (beatXfer) begin
            for (int k = 0; k < NUM_PACKETS - 1; k++) begin
                if (count_q == CNT_W'(k)) begin
                    buffer_d[k*AXI_WIDTH +: AXI_WIDTH] = tdata;
                end
            end
            if (count_q == LAST_IDX) begin
                buffer_d[LAST_LO +: LAST_W] = tdata[LAST_W-1:0];
                count_d = '0;
                state_d = HOLD;
`ifdef AXIS_INPUT_BUFFER_TLAST_CHECK_EN
                errMissing_d = !tlast;
`endif
            end else begin
                count_d = count_q + CNT_W'(1);
`ifdef AXIS_INPUT_BUFFER_TLAST_CHECK_EN
                // An early tlast abandons the partial buffer. Restarting the
                // count realigns the block to the next packet. Stale slices
                // need no clearing because every slice is rewritten.
                if (tlast) begin
                    count_d    = '0;
                    errEarly_d = 1'b1;
                end
`endif
            end
        end else if ((state_q == HOLD) && output_buffer_ready) begin
            state_d = FILL;
        end
    end

    // State, counter, buffer and error registers. The asynchronous reset
    // discards any partial buffer and clears the visible buffer contents.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= FILL;
            count_q      <= '0;
            buffer_q     <= '0;
            errEarly_q   <= 1'b0;
            errMissing_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            buffer_q     <= buffer_d;
            errEarly_q   <= errEarly_d;
            errMissing_q <= errMissing_d;
        end
    end

endmodule

// File: tb/tb_axi4stream_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_axi4stream_input_buffer
//
// Directed bench for axi4stream_input_buffer. It uses two instances:
//   dut   - default configuration, 8-bit beats into an 80-bit buffer
//   dutB  - 8-bit beats into a 35-bit buffer, where the final beat is partial
// Inputs change one time unit after the rising edge, and outputs are checked
// at that same point. The tlast-framing section follows the
// AXIS_INPUT_BUFFER_TLAST_CHECK_EN setting that the design is built with.
// ---------------------------------------------------------------------------
module tb_axi4stream_input_buffer;

    logic        aclk;
    logic        areset;

    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [79:0] outputBuffer;
    logic        outputBufferValid;
    logic        outputBufferReady;
    logic        errEarly;
    logic        errMissing;

    logic [7:0]  tdataB;
    logic        tvalidB;
    logic        tlastB;
    logic        treadyB;
    logic [34:0] outputBufferB;
    logic        outputBufferValidB;
    logic        outputBufferReadyB;
    logic        errEarlyB;
    logic        errMissingB;

    int total = 0;
    int bad   = 0;

    logic [7:0]  beatsA [10] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF,
                                 8'hBA, 8'hB0, 8'hFE, 8'hCA, 8'hFF};
    logic [79:0] expA = 80'hFFCAFEB0BAFFDEADBEEF;
    logic [79:0] expB2B [3] = '{80'h0A090807060504030201,
                                80'h2A292827262524232221,
                                80'h4A494847464544434241};

    axi4stream_input_buffer #(
        .AXI_WIDTH   (8),
        .BUFFER_WIDTH(80),
        .NUM_PACKETS (10)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .tdata              (tdata),
        .tvalid             (tvalid),
        .tlast              (tlast),
        .tready             (tready),
        .output_buffer      (outputBuffer),
        .output_buffer_valid(outputBufferValid),
        .output_buffer_ready(outputBufferReady),
        .err_early_tlast    (errEarly),
        .err_missing_tlast  (errMissing)
    );

    axi4stream_input_buffer #(
        .AXI_WIDTH   (8),
        .BUFFER_WIDTH(35),
        .NUM_PACKETS (5)
    ) dutB (
        .aclk               (aclk),
        .areset             (areset),
        .tdata              (tdataB),
        .tvalid             (tvalidB),
        .tlast              (tlastB),
        .tready             (treadyB),
        .output_buffer      (outputBufferB),
        .output_buffer_valid(outputBufferValidB),
        .output_buffer_ready(outputBufferReadyB),
        .err_early_tlast    (errEarlyB),
        .err_missing_tlast  (errMissingB)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One comparison. A failure is counted and reported, and the run carries
    // on toward the summary line.
    task automatic checkOutput(input string tag,
                               input logic [79:0] observed,
                               input logic [79:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one beat to the 80-bit instance and let one edge pass.
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        tvalid = 1'b1;
        tdata  = data;
        tlast  = last;
        @(posedge aclk);
        #1;
    endtask

    // Present one beat to the 35-bit instance and let one edge pass.
    task automatic applyStimulusB(input logic [7:0] data, input logic last);
        tvalidB = 1'b1;
        tdataB  = data;
        tlastB  = last;
        @(posedge aclk);
        #1;
    endtask

    task automatic idleCycle();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset = 1'b1;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0; outputBufferReady = 1'b0;
        tdataB = '0; tvalidB = 1'b0; tlastB = 1'b0; outputBufferReadyB = 1'b0;

        // ---- reset state ----
        idleCycle();
        idleCycle();
        checkOutput("rst_tready", 80'(tready), 80'(1'b0));
        checkOutput("rst_valid", 80'(outputBufferValid), 80'(1'b0));
        checkOutput("rst_buffer", outputBuffer, 80'h0);
        checkOutput("rst_errs", 80'({errEarly, errMissing}), 80'(2'b00));
        areset = 1'b0;
        #1;
        checkOutput("rst_release_tready", 80'(tready), 80'(1'b1));

        // ---- single buffer, downstream not ready ----
        for (int k = 0; k < 10; k++) begin
            applyStimulus(beatsA[k], k == 9);
            if (k == 8) checkOutput("one_valid_early", 80'(outputBufferValid), 80'(1'b0));
        end
        tvalid = 1'b0; tlast = 1'b0;
        checkOutput("one_valid", 80'(outputBufferValid), 80'(1'b1));
        checkOutput("one_data", outputBuffer, expA);
        checkOutput("one_tready_hold", 80'(tready), 80'(1'b0));
        idleCycle();
        idleCycle();
        checkOutput("one_still_valid", 80'(outputBufferValid), 80'(1'b1));
        checkOutput("one_still_tready", 80'(tready), 80'(1'b0));
        outputBufferReady = 1'b1;
        idleCycle();
        checkOutput("one_release_valid", 80'(outputBufferValid), 80'(1'b0));
        checkOutput("one_release_tready", 80'(tready), 80'(1'b1));
        checkOutput("one_buffer_kept", outputBuffer, expA);

        // ---- three back-to-back buffers with ready held high ----
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 10; k++) applyStimulus(8'(b * 32 + k + 1), k == 9);
            checkOutput($sformatf("b2b%0d_valid", b), 80'(outputBufferValid), 80'(1'b1));
            checkOutput($sformatf("b2b%0d_data", b), outputBuffer, expB2B[b]);
            checkOutput($sformatf("b2b%0d_tready", b), 80'(tready), 80'(1'b0));
            // The next buffer's first beat is already presented, so it waits
            // through the one-cycle bubble.
            if (b < 2) begin
                tdata = 8'(b * 32 + 33);
                tlast = 1'b0;
            end else begin
                tvalid = 1'b0;
                tlast  = 1'b0;
            end
            idleCycle();
            checkOutput($sformatf("b2b%0d_bubble_valid", b), 80'(outputBufferValid), 80'(1'b0));
            checkOutput($sformatf("b2b%0d_bubble_tready", b), 80'(tready), 80'(1'b1));
        end
        outputBufferReady = 1'b0;

        // ---- tvalid toggled every other cycle ----
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 1) begin
                applyStimulus(beatsA[c / 2], c == 19);
            end else begin
                tvalid = 1'b0; tdata = 8'h55; tlast = 1'b0;
                idleCycle();
            end
            if (c == 18) checkOutput("gap_valid_early", 80'(outputBufferValid), 80'(1'b0));
        end
        tvalid = 1'b0; tlast = 1'b0;
        checkOutput("gap_valid", 80'(outputBufferValid), 80'(1'b1));
        checkOutput("gap_data", outputBuffer, expA);
        outputBufferReady = 1'b1;
        idleCycle();
        outputBufferReady = 1'b0;
        checkOutput("gap_release", 80'(outputBufferValid), 80'(1'b0));

        // ---- tlast framing ----
`ifdef AXIS_INPUT_BUFFER_TLAST_CHECK_EN
        for (int k = 0; k < 5; k++) applyStimulus(beatsA[k], k == 4);
        checkOutput("early_pulse", 80'(errEarly), 80'(1'b1));
        checkOutput("early_no_valid", 80'(outputBufferValid), 80'(1'b0));
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'(32 + k + 1), k == 9);
            if (k == 0) checkOutput("early_pulse_end", 80'(errEarly), 80'(1'b0));
            if (k == 8) checkOutput("early_resync_count", 80'(outputBufferValid), 80'(1'b0));
        end
        tvalid = 1'b0; tlast = 1'b0;
        checkOutput("early_next_valid", 80'(outputBufferValid), 80'(1'b1));
        checkOutput("early_next_data", outputBuffer, expB2B[1]);
        checkOutput("early_no_missing", 80'(errMissing), 80'(1'b0));
        outputBufferReady = 1'b1;
        idleCycle();
        outputBufferReady = 1'b0;

        for (int k = 0; k < 10; k++) applyStimulus(8'(64 + k + 1), 1'b0);
        tvalid = 1'b0;
        checkOutput("missing_pulse", 80'(errMissing), 80'(1'b1));
        checkOutput("missing_valid", 80'(outputBufferValid), 80'(1'b1));
        checkOutput("missing_data", outputBuffer, expB2B[2]);
        outputBufferReady = 1'b1;
        idleCycle();
        outputBufferReady = 1'b0;
        checkOutput("missing_pulse_end", 80'(errMissing), 80'(1'b0));
`else
        // tlast is on beat 4 and absent on beat 9. Framing by count must
        // ignore both, and the error outputs stay low.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'(32 + k + 1), k == 4);
            if (k == 4) begin
                checkOutput("notlast_no_early", 80'(errEarly), 80'(1'b0));
                checkOutput("notlast_no_valid", 80'(outputBufferValid), 80'(1'b0));
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
        checkOutput("notlast_valid", 80'(outputBufferValid), 80'(1'b1));
        checkOutput("notlast_data", outputBuffer, expB2B[1]);
        checkOutput("notlast_no_missing", 80'(errMissing), 80'(1'b0));
        outputBufferReady = 1'b1;
        idleCycle();
        outputBufferReady = 1'b0;
`endif

        // ---- 35-bit buffer, partial final beat ----
        for (int k = 0; k < 5; k++) applyStimulusB(8'hFF, k == 4);
        tvalidB = 1'b0; tlastB = 1'b0;
        checkOutput("w35_ff_valid", 80'(outputBufferValidB), 80'(1'b1));
        checkOutput("w35_ff_data", 80'(outputBufferB), 80'(35'h7_FFFFFFFF));
        outputBufferReadyB = 1'b1;
        idleCycle();
        outputBufferReadyB = 1'b0;
        applyStimulusB(8'h01, 1'b0);
        applyStimulusB(8'h02, 1'b0);
        applyStimulusB(8'h03, 1'b0);
        applyStimulusB(8'h04, 1'b0);
        applyStimulusB(8'hFA, 1'b1);
        tvalidB = 1'b0; tlastB = 1'b0;
        checkOutput("w35_mix_data", 80'(outputBufferB), 80'(35'h2_04030201));
        outputBufferReadyB = 1'b1;
        idleCycle();
        outputBufferReadyB = 1'b0;

        // ---- reset in the middle of a buffer ----
        for (int k = 0; k < 6; k++) applyStimulus(beatsA[k], 1'b0);
        tvalid = 1'b0;
        areset = 1'b1;
        #1;
        checkOutput("midrst_tready", 80'(tready), 80'(1'b0));
        checkOutput("midrst_buffer", outputBuffer, 80'h0);
        idleCycle();
        checkOutput("midrst_tready_held", 80'(tready), 80'(1'b0));
        areset = 1'b0;
        #1;
        checkOutput("midrst_tready_back", 80'(tready), 80'(1'b1));
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'(64 + k + 1), k == 9);
            if (k == 3) checkOutput("midrst_no_residue_valid", 80'(outputBufferValid), 80'(1'b0));
            if (k == 8) checkOutput("midrst_valid_early", 80'(outputBufferValid), 80'(1'b0));
        end
        tvalid = 1'b0; tlast = 1'b0;
        checkOutput("midrst_valid", 80'(outputBufferValid), 80'(1'b1));
        checkOutput("midrst_data", outputBuffer, expB2B[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4stream_input_buffer.md
# axi4stream_input_buffer

AXI4-Stream slave that deserializes a stream of narrow beats into one wide parallel buffer. It is the receive-side mirror of the output-buffer serializer and sits directly downstream of it in the video pipeline. It collects `NUM_PACKETS` beats into `output_buffer`, then presents the buffer with a valid/ready handshake to the next processing stage. It applies back-pressure through `tready` while a completed buffer is waiting to be taken.

## Interface
- `AXI_WIDTH`, default 8: stream beat width in bits.
- `BUFFER_WIDTH`, default 80: assembled buffer width in bits; need not be a multiple of `AXI_WIDTH`.
- `NUM_PACKETS`, default 10: beats per buffer; must equal ceil(`BUFFER_WIDTH`/`AXI_WIDTH`).
- `aclk`, input, 1: single clock; all logic is rising-edge.
- `areset`, input, 1: asynchronous, active-high reset.
- `tdata`, input, `AXI_WIDTH`: stream data.
- `tvalid`, input, 1: upstream data valid.
- `tlast`, input, 1: marks the final beat of a buffer.
- `tready`, output, 1: this block accepts a beat.
- `output_buffer`, output, `BUFFER_WIDTH`: assembled buffer.
- `output_buffer_valid`, output, 1: `output_buffer` is complete and stable.
- `output_buffer_ready`, input, 1: downstream takes the buffer.
- `err_early_tlast`, output, 1: one-cycle pulse; `tlast` arrived before beat `NUM_PACKETS-1`.
- `err_missing_tlast`, output, 1: one-cycle pulse; the final beat arrived without `tlast`.

## Operation
- There are two states.
  - FILL: `tready`=1, `output_buffer_valid`=0.
  - HOLD: `tready`=0, `output_buffer_valid`=1.
- Beat transfer occurs when `tvalid` && `tready` at a rising edge.
- Beat index k (0-based) is written to `output_buffer[k*AXI_WIDTH +: AXI_WIDTH]`, LSB-first.
  - This matches the upstream serializer's send order.
  - For the last beat, only its low `BUFFER_WIDTH-(NUM_PACKETS-1)*AXI_WIDTH` bits are stored; excess `tdata` bits are ignored.
- The beat counter has width `$clog2(NUM_PACKETS)` (minimum 1).
  - It increments on each transfer.
  - On the transfer of beat `NUM_PACKETS-1`, the counter clears and the state goes to HOLD.
- HOLD to FILL: on a rising edge with `output_buffer_ready`=1. `output_buffer` keeps its value until it is overwritten by new beats.
- Unwritten bits are never cleared between buffers. Every bit is overwritten each buffer.
- `tvalid`=0 in FILL leaves the counter and buffer unchanged, with no timeout.
- Reset, asynchronous at any point including mid-buffer:
  - state=FILL, counter=0, `output_buffer`=0, `output_buffer_valid`=0, error pulses=0.
  - `tready` is forced to 0 while `areset` is high.
  - A partial buffer is discarded.

## Timing
- `tready` is the combinational decode of the state (and `!areset`). It is not a function of `tvalid`.
- `output_buffer_valid` rises on the same edge that accepts the final beat, so it is visible the following cycle. Latency from first beat to valid is `NUM_PACKETS` cycles at full rate.
- At most one buffer is completed per `NUM_PACKETS+1` cycles. The HOLD-to-FILL edge is a mandatory one-cycle bubble with no beat accepted on it.
- If `output_buffer_ready` is held at 1, HOLD lasts exactly one cycle.
- Error pulses are registered and high for exactly the cycle after the offending transfer.

## Configuration
- Macro `AXIS_INPUT_BUFFER_TLAST_CHECK_EN`.
- Defined:
  - `tlast` on beat k < `NUM_PACKETS-1` pulses `err_early_tlast`, discards the partial buffer and resets the counter to 0. The state stays FILL, which resynchronizes to the next packet.
  - Missing `tlast` on the final beat pulses `err_missing_tlast`, but the buffer is still delivered.
- Undefined:
  - `tlast` is ignored and framing is purely by count.
  - Both error outputs are tied to 0.

## Structure
- Shared package `axi4stream_pkg`:
  - state enum (FILL, HOLD);
  - a counter-width helper function;
  - a last-beat-width constant function shared with the output-buffer serializer.
- No sub-module. The counter, state register and beat write-enable decode are inline.

## Test plan
- Send beats EF,BE,AD,DE,FF,BA,B0,FE,CA,FF with `tvalid`=1 continuously, `tlast` on beat 9 and `output_buffer_ready`=0.
  - Expected: `output_buffer`=FFCAFEB0BAFFDEADBEEF and valid high after the 10th edge.
  - `tready` low until ready.
- Hold `output_buffer_ready`=1 and stream 3 buffers back to back.
  - Expected: each buffer valid for 1 cycle.
  - Exactly one bubble cycle (`tready`=0) between buffers; all data correct.
- Toggle `tvalid` every other cycle across a buffer.
  - Expected: same buffer contents; valid after 20 cycles.
- With the macro defined, assert `tlast` on beat 4, then send a correct 10-beat buffer.
  - Expected: `err_early_tlast` pulses once.
  - Only the second buffer is delivered, correct.
- With `BUFFER_WIDTH`=35, `NUM_PACKETS`=5, send 5 beats of FF.
  - Expected: `output_buffer`=7_FFFFFFFF (35 bits).
- Assert `areset` after beat 6.
  - Expected: `tready`=0 during reset, then 1.
  - The next full 10 beats produce the correct buffer with no residue from the discarded partial buffer.
